gen_scheduler: RTL and testbench

GEN_SCHEDULER -- requirements
Module: gen_scheduler

---
 rtl/gen_scheduler.sv | 170 +++++++++++++++++
 tb/tb_gen_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_scheduler.sv
// Generation scheduler for a Game-of-Life display pipeline.
// Sequences seeding, timed or stepped generation updates and frame-locked
// buffer swaps, and keeps the generation and statistics-sample counters.
module gen_scheduler #(
    parameter int LOG_MAX_SPEED       = 5,
    parameter int LOG_NUM_SEED        = 3,
    parameter int GRAPH_SAMPLE_PERIOD = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     vsync_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     pause_in,
    input  logic                     step_in,
    input  logic                     load_in,
    input  logic [LOG_NUM_SEED-1:0]  seed_in,
    output logic                     seed_start_out,
    output logic [LOG_NUM_SEED-1:0]  seed_idx_out,
    input  logic                     seed_done_in,
    output logic                     gen_start_out,
    input  logic                     gen_done_in,
    output logic                     swap_out,
    output logic [15:0]              gen_count_out,
    output logic                     sample_out,
    output logic                     busy_out
);

    localparam int MAX_SPEED = 2 ** LOG_MAX_SPEED;

    typedef enum logic [2:0] {
        SEED_REQ,
        SEEDING,
        WAIT,
        COMPUTE,
        SYNC
    } state_t;

    state_t      state;
    logic        vsync_q;
    logic        frame_tick;
    logic [5:0]  frame_cnt;
    logic [7:0]  sample_cnt;
    logic [7:0]  sample_next;
    logic        seed_flag;
    logic        load_pending;
    logic        go_gen;

    // Frame tick is the falling edge of vsync against its registered copy.
    assign frame_tick  = vsync_q & ~vsync_in;
    assign sample_next = sample_cnt + 8'd1;
    assign busy_out    = (state == SEED_REQ) || (state == SEEDING) || (state == COMPUTE);

    // Decide whether a generation may start from WAIT this cycle.
    always_comb begin
        // NOTE: default first so no path leaves go_gen unassigned (no latch).
        go_gen = 1'b0;
        if (pause_in) begin
            go_gen = step_in;
        end else begin
            go_gen = (int'(frame_cnt) >= (MAX_SPEED - int'(speed_in)));
        end
    end

    // Registered copy of vsync for edge detection; idle-high after reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vsync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            vsync_q <= vsync_in;
        end
    end

    // Main scheduler FSM with its counters and registered pulse outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= SEED_REQ;
            seed_idx_out   <= '0;
            frame_cnt      <= '0;
            gen_count_out  <= '0;
            sample_cnt     <= '0;
            seed_flag      <= 1'b0;
            load_pending   <= 1'b0;
            seed_start_out <= 1'b0;
            gen_start_out  <= 1'b0;
            swap_out       <= 1'b0;
            sample_out     <= 1'b0;
        end else begin
            seed_start_out <= 1'b0;
            gen_start_out  <= 1'b0;
            swap_out       <= 1'b0;
            sample_out     <= 1'b0;

            // Frame counter runs in every state and saturates; the
            // generation-start clear below overrides it.
            if (frame_tick && (frame_cnt != 6'd63)) begin
                frame_cnt <= frame_cnt + 6'd1;
            end

            case (state)
                SEED_REQ: begin
                    seed_start_out <= 1'b1;
                    state          <= SEEDING;
                end

                SEEDING: begin
                    if (seed_done_in) begin
                        seed_flag <= 1'b1;
                        state     <= SYNC;
                    end
                end

                WAIT: begin
                    // A load outranks any generation request, including step.
                    if (load_in) begin
                        seed_idx_out <= seed_in;
                        state        <= SEED_REQ;
                    end else if (go_gen) begin
                        gen_start_out <= 1'b1;
                        frame_cnt     <= '0;
                        state         <= COMPUTE;
                    end
                end

                COMPUTE: begin
                    // The engine always runs to completion; a load only
                    // diverts where we go once it finishes.
                    if (load_in) begin
                        seed_idx_out <= seed_in;
                        load_pending <= 1'b1;
                    end
                    if (gen_done_in) begin
                        if (load_pending || load_in) begin
                            load_pending <= 1'b0;
                            state        <= SEED_REQ;
                        end else begin
                            seed_flag <= 1'b0;
                            state     <= SYNC;
                        end
                    end
                end

                SYNC: begin
                    if (load_in) begin
                        seed_idx_out <= seed_in;
                        state        <= SEED_REQ;
                    end else if (frame_tick) begin
                        swap_out <= 1'b1;
                        state    <= WAIT;
                        if (seed_flag) begin
                            gen_count_out <= '0;
                            sample_cnt    <= '0;
                        end else begin
                            gen_count_out <= gen_count_out + 16'd1;
                            if (sample_next == 8'(GRAPH_SAMPLE_PERIOD)) begin
                                sample_out <= 1'b1;
                                sample_cnt <= '0;
                            end else begin
                                sample_cnt <= sample_next;
                            end
                        end
                    end
                end

                default: state <= SEED_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard testbench for gen_scheduler: directed stimulus pushes the
// expected pulse events, a monitor pops and compares them as they appear.
module tb_gen_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        vsync_in;
    logic [4:0]  speed_in;
    logic        pause_in;
    logic        step_in;
    logic        load_in;
    logic [2:0]  seed_in;
    logic        seed_start_out;
    logic [2:0]  seed_idx_out;
    logic        seed_done_in;
    logic        gen_start_out;
    logic        gen_done_in;
    logic        swap_out;
    logic [15:0] gen_count_out;
    logic        sample_out;
    logic        busy_out;

    typedef enum int {EV_SEED = 0, EV_GEN = 1, EV_SWAP = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       data;
        int       sample;
    } ev_t;

    ev_t exp_q[$];
    int  gs_ticks[$];
    int  n_checks   = 0;
    int  n_fail     = 0;
    int  tick_count = 0;
    int  gen_starts = 0;

    always #5 clk_in = ~clk_in;

    gen_scheduler dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .vsync_in       (vsync_in),
        .speed_in       (speed_in),
        .pause_in       (pause_in),
        .step_in        (step_in),
        .load_in        (load_in),
        .seed_in        (seed_in),
        .seed_start_out (seed_start_out),
        .seed_idx_out   (seed_idx_out),
        .seed_done_in   (seed_done_in),
        .gen_start_out  (gen_start_out),
        .gen_done_in    (gen_done_in),
        .swap_out       (swap_out),
        .gen_count_out  (gen_count_out),
        .sample_out     (sample_out),
        .busy_out       (busy_out)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int d, input int s);
        ev_t e;
        e.kind   = k;
        e.data   = d;
        e.sample = s;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input int d, input int s);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", int'(k), -1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            if (k == e.kind && k != EV_GEN) begin
                check("event_data", d, e.data);
                if (k == EV_SWAP) check("event_sample", s, e.sample);
            end
        end
    endtask

    task automatic frame();
        vsync_in = 1'b0;
        tick_count++;
        repeat (10) @(negedge clk_in);
        vsync_in = 1'b1;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic wait_gen_start(input string name);
        for (int i = 0; i < 40 && !gen_start_out; i++) @(negedge clk_in);
        check(name, int'(gen_start_out), 1);
    endtask

    // Monitor: every presented pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_n_in === 1'b1) begin
                if (seed_start_out) observe(EV_SEED, int'(seed_idx_out), 0);
                if (gen_start_out) begin
                    gen_starts++;
                    gs_ticks.push_back(tick_count);
                    observe(EV_GEN, 0, 0);
                end
                if (swap_out) observe(EV_SWAP, int'(gen_count_out), int'(sample_out));
                else if (sample_out) check("sample_without_swap", int'(swap_out), 1);
            end
        end
    end

    // Life engine model: finishes 5 cycles after each start.
    initial begin
        gen_done_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (gen_start_out) begin
                repeat (5) @(negedge clk_in);
                gen_done_in = 1'b1;
                @(negedge clk_in);
                gen_done_in = 1'b0;
            end
        end
    end

    // Seed writer model: finishes 10 cycles after each start.
    initial begin
        seed_done_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (seed_start_out) begin
                repeat (10) @(negedge clk_in);
                seed_done_in = 1'b1;
                @(negedge clk_in);
                seed_done_in = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b1;
        vsync_in = 1'b1;
        speed_in = 5'd31;
        pause_in = 1'b1;
        step_in  = 1'b0;
        load_in  = 1'b0;
        seed_in  = 3'd0;
        #3 rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Reset state.
        check("reset_busy", int'(busy_out), 1);
        check("reset_seed_start", int'(seed_start_out), 0);
        check("reset_gen_start", int'(gen_start_out), 0);
        check("reset_swap", int'(swap_out), 0);
        check("reset_gen_count", int'(gen_count_out), 0);
        check("reset_seed_idx", int'(seed_idx_out), 0);

        // First clock after release emits the seed request; seed swap on tick.
        expect_ev(EV_SEED, 0, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("release_seed_start_latency", int'(seed_start_out), 1);
        expect_ev(EV_SWAP, 0, 0);
        repeat (15) @(negedge clk_in);
        frame();
        check("seed_swap_gen_count", int'(gen_count_out), 0);

        // Fastest speed: one generation per frame, samples on swaps 2 and 4.
        expect_ev(EV_GEN, 0, 0);
        for (int g = 1; g <= 5; g++) begin
            expect_ev(EV_SWAP, g, (g % 2 == 0) ? 1 : 0);
            if (g < 5) expect_ev(EV_GEN, 0, 0);
        end
        pause_in = 1'b0;
        repeat (10) @(negedge clk_in);
        repeat (4) frame();
        pause_in = 1'b1;
        frame();
        check("speed31_gen_starts", gen_starts, 5);
        check("speed31_ticks_between", gs_ticks[2] - gs_ticks[1], 1);

        // Slowest speed: 32 frame ticks between generation starts.
        expect_ev(EV_GEN, 0, 0);
        expect_ev(EV_SWAP, 6, 1);
        expect_ev(EV_GEN, 0, 0);
        expect_ev(EV_SWAP, 7, 0);
        speed_in = 5'd0;
        pause_in = 1'b0;
        for (int f = 0; f < 80 && gen_starts < 7; f++) frame();
        check("speed0_gen7_reached", gen_starts, 7);
        pause_in = 1'b1;
        frame();
        check("speed0_ticks_between", gs_ticks[6] - gs_ticks[5], 32);

        // Paused: 100 frames without a generation, then one step.
        repeat (100) frame();
        check("paused_no_gen", gen_starts, 7);
        expect_ev(EV_GEN, 0, 0);
        expect_ev(EV_SWAP, 8, 1);
        step_in = 1'b1;
        @(negedge clk_in);
        step_in = 1'b0;
        repeat (10) @(negedge clk_in);
        frame();
        check("step_one_gen", gen_starts, 8);

        // Load during COMPUTE: generation not swapped, reseed with index 5.
        expect_ev(EV_GEN, 0, 0);
        expect_ev(EV_SEED, 5, 0);
        expect_ev(EV_SWAP, 0, 0);
        step_in = 1'b1;
        @(negedge clk_in);
        step_in = 1'b0;
        wait_gen_start("compute_load_gen_start");
        repeat (2) @(negedge clk_in);
        seed_in = 3'd5;
        load_in = 1'b1;
        @(negedge clk_in);
        load_in = 1'b0;
        repeat (25) @(negedge clk_in);
        frame();
        check("compute_load_gen_count", int'(gen_count_out), 0);
        check("compute_load_seed_idx", int'(seed_idx_out), 5);

        // Load and step together while paused in WAIT: load wins.
        expect_ev(EV_SEED, 2, 0);
        expect_ev(EV_SWAP, 0, 0);
        seed_in = 3'd2;
        load_in = 1'b1;
        step_in = 1'b1;
        @(negedge clk_in);
        load_in = 1'b0;
        step_in = 1'b0;
        @(negedge clk_in);
        check("load_step_seed_latency", int'(seed_start_out), 1);
        // A load during SEEDING is ignored.
        repeat (3) @(negedge clk_in);
        seed_in = 3'd7;
        load_in = 1'b1;
        @(negedge clk_in);
        load_in = 1'b0;
        check("seeding_load_ignored", int'(seed_idx_out), 2);
        repeat (15) @(negedge clk_in);
        frame();
        check("load_step_no_gen", gen_starts, 9);

        // Stale done pulses in WAIT are ignored.
        gen_done_in = 1'b1;
        @(negedge clk_in);
        gen_done_in  = 1'b0;
        seed_done_in = 1'b1;
        @(negedge clk_in);
        seed_done_in = 1'b0;
        repeat (5) @(negedge clk_in);
        check("stale_done_busy", int'(busy_out), 0);

        // Reset mid-COMPUTE; the engine's late done lands in SEEDING.
        expect_ev(EV_GEN, 0, 0);
        step_in = 1'b1;
        @(negedge clk_in);
        step_in = 1'b0;
        wait_gen_start("midreset_gen_start");
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check("midreset_busy", int'(busy_out), 1);
        check("midreset_seed_idx", int'(seed_idx_out), 0);
        check("midreset_gen_start", int'(gen_start_out), 0);
        expect_ev(EV_SEED, 0, 0);
        expect_ev(EV_SWAP, 0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (18) @(negedge clk_in);
        frame();
        check("midreset_gen_starts", gen_starts, 10);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
